axis_tuple_gearbox: RTL and testbench

- Parametrised byte-granular AXI-Stream width converter between the DMA read stream and a tuple-consuming kernel, e.g. 512-bit DMA beats to 320-bit HyperLogLog input tuples.
- Generalises the fixed 512-to-320 converter: any IN_WIDTH/OUT_WIDTH ratio, partial-beat packing across input beats, and packet-boundary flush.
- Integrates the tuples-consumed/produced statistics with a configurable tuple size, replacing hard-coded keep-pattern decoding in the role.

---
 rtl/axis_tuple_gearbox.sv | 141 ++++++++++++++
 tb/tb_axis_tuple_gearbox.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_tuple_gearbox.sv
// Byte-granular AXI-Stream width converter with packet flush and tuple statistics; data accepted in cycle N is visible on m_axis from N+1.
// s_axis_tready depends only on registered fill state; m_axis holds its beat until taken.
module axis_tuple_gearbox #(
    parameter int IN_WIDTH    = 512,
    parameter int OUT_WIDTH   = 320,
    parameter int TUPLE_BYTES = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [IN_WIDTH-1:0]      s_axis_tdata,
    input  logic [IN_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [OUT_WIDTH-1:0]     m_axis_tdata,
    output logic [OUT_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                     m_axis_tlast,
    input  logic                     stat_clear,
    output logic [CNT_WIDTH-1:0]     stat_tuples_in,
    output logic [CNT_WIDTH-1:0]     stat_tuples_out,
    output logic                     err_keep
);

    localparam int IB   = IN_WIDTH / 8;
    localparam int OB   = OUT_WIDTH / 8;
    localparam int BB   = IB + OB;
    localparam int LW   = $clog2(BB + 1);
    localparam int KW   = $clog2(IB + 1);
    localparam int PADW = BB * 8 - IN_WIDTH;

    logic [BB*8-1:0]      buf_q, buf_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 last_q, last_d;
    logic                 run_q;
    logic [CNT_WIDTH-1:0] tin_q, tin_d, tout_q, tout_d;
    logic                 err_q, err_d;

    logic [KW-1:0]        n_in;
    logic                 found, keep_err;
    logic [IN_WIDTH-1:0]  in_dat;
    logic [LW-1:0]        popped, base;
    logic                 s_hs, m_hs;

    // n_in is the position of the first cleared keep bit; anything above it is discarded
    always_comb begin
        n_in     = KW'(IB);
        found    = 1'b0;
        keep_err = 1'b0;
        in_dat   = '0;
        for (int i = 0; i < IB; i++) begin
            if (!found && s_axis_tkeep[i]) begin
                in_dat[i*8 +: 8] = s_axis_tdata[i*8 +: 8];
            end else if (!found) begin
                n_in  = KW'(i);
                found = 1'b1;
            end else if (s_axis_tkeep[i]) begin
                keep_err = 1'b1;
            end
        end
    end

    always_comb begin
        m_axis_tkeep = '0;
        for (int i = 0; i < OB; i++) begin
            m_axis_tkeep[i] = (LW'(i) < level_q);
        end
    end

    assign s_axis_tready = run_q && (level_q <= LW'(OB)) && !last_q;
    assign m_axis_tvalid = (level_q >= LW'(OB)) || last_q;
    assign m_axis_tlast  = last_q && (level_q <= LW'(OB));
    // Bytes above level are kept at zero, so the low window needs no masking
    assign m_axis_tdata  = buf_q[OUT_WIDTH-1:0];

    assign s_hs   = s_axis_tvalid && s_axis_tready;
    assign m_hs   = m_axis_tvalid && m_axis_tready;
    assign popped = m_hs ? ((level_q >= LW'(OB)) ? LW'(OB) : level_q) : '0;
    assign base   = level_q - popped;

    always_comb begin
        buf_d   = buf_q >> {popped, 3'b000};
        level_d = base;
        last_d  = last_q;
        if (s_hs) begin
            buf_d   = buf_d | ({{PADW{1'b0}}, in_dat} << {base, 3'b000});
            level_d = base + LW'(n_in);
        end
        if (m_hs && m_axis_tlast) begin
            last_d = 1'b0;
        end
        if (s_hs && s_axis_tlast) begin
            last_d = 1'b1;
        end
    end

    always_comb begin
        tin_d  = tin_q;
        tout_d = tout_q;
        err_d  = err_q;
        if (s_hs) begin
            tin_d = tin_q + CNT_WIDTH'(n_in / KW'(TUPLE_BYTES));
            err_d = err_q | keep_err;
        end
        if (m_hs) begin
            tout_d = tout_q + CNT_WIDTH'(popped / LW'(TUPLE_BYTES));
        end
        if (stat_clear) begin
            tin_d  = '0;
            tout_d = '0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            buf_q   <= '0;
            level_q <= '0;
            last_q  <= 1'b0;
            run_q   <= 1'b0;
            tin_q   <= '0;
            tout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            level_q <= level_d;
            last_q  <= last_d;
            run_q   <= 1'b1;
            tin_q   <= tin_d;
            tout_q  <= tout_d;
            err_q   <= err_d;
        end
    end

    assign stat_tuples_in  = tin_q;
    assign stat_tuples_out = tout_q;
    assign err_keep        = err_q;

endmodule

// File: tb/tb_axis_tuple_gearbox.sv
// Directed bench for axis_tuple_gearbox at default parameters (512 -> 320 bits, 8-byte tuples).
module tb_axis_tuple_gearbox;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         s_vld, s_rdy, s_last;
    logic [511:0] s_dat;
    logic [63:0]  s_keep;
    logic         m_vld, m_rdy, m_last;
    logic [319:0] m_dat;
    logic [39:0]  m_keep;
    logic         stat_clear;
    logic [31:0]  tin, tout;
    logic         err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [319:0] q_dat[$];
    logic [39:0]  q_keep[$];
    logic         q_last[$];

    always #5 aclk = ~aclk;

    axis_tuple_gearbox dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_axis_tvalid   (s_vld),
        .s_axis_tready   (s_rdy),
        .s_axis_tdata    (s_dat),
        .s_axis_tkeep    (s_keep),
        .s_axis_tlast    (s_last),
        .m_axis_tvalid   (m_vld),
        .m_axis_tready   (m_rdy),
        .m_axis_tdata    (m_dat),
        .m_axis_tkeep    (m_keep),
        .m_axis_tlast    (m_last),
        .stat_clear      (stat_clear),
        .stat_tuples_in  (tin),
        .stat_tuples_out (tout),
        .err_keep        (err)
    );

    // Output beats are captured mid-cycle, ahead of the edge that completes them
    always @(negedge aclk) begin
        if (aresetn && m_vld && m_rdy) begin
            q_dat.push_back(m_dat);
            q_keep.push_back(m_keep);
            q_last.push_back(m_last);
        end
    end

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [511:0] pat(input logic [7:0] b);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[i*8 +: 8] = b + 8'(i);
        return r;
    endfunction

    function automatic logic [319:0] bmask(input int nbytes);
        logic [319:0] r;
        r = '0;
        for (int i = 0; i < nbytes; i++) r[i*8 +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic send(input logic [511:0] d, input logic [63:0] k, input logic l);
        int t = 0;
        @(posedge aclk); #1;
        s_vld = 1'b1; s_dat = d; s_keep = k; s_last = l;
        @(negedge aclk);
        while (!s_rdy && t < 200) begin
            @(negedge aclk);
            t++;
        end
        check("send_rdy", 320'(s_rdy), 320'(1));
        @(posedge aclk); #1;
        s_vld = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (q_dat.size() < n && t < 200) begin
            @(negedge aclk);
            t++;
        end
        check("out_count", 320'(q_dat.size()), 320'(n));
    endtask

    task automatic clr_q();
        q_dat.delete(); q_keep.delete(); q_last.delete();
    endtask

    task automatic pulse_clear();
        @(posedge aclk); #1 stat_clear = 1'b1;
        @(posedge aclk); #1 stat_clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] pv;
        logic [319:0] exp_d, snap;

        s_vld = 1'b0; s_dat = '0; s_keep = '0; s_last = 1'b0;
        m_rdy = 1'b1; stat_clear = 1'b0;

        #12;
        check("rst_s_rdy", 320'(s_rdy), 320'(0));
        check("rst_m_vld", 320'(m_vld), 320'(0));
        check("rst_m_dat", m_dat, 320'(0));
        check("rst_m_keep", 320'(m_keep), 320'(0));
        check("rst_m_last", 320'(m_last), 320'(0));
        check("rst_tin", 320'(tin), 320'(0));
        check("rst_tout", 320'(tout), 320'(0));
        check("rst_err", 320'(err), 320'(0));
        @(negedge aclk) aresetn = 1'b1;

        // Five full beats -> eight full 40-byte beats
        for (int p = 0; p < 5; p++) send(pat(8'(p * 64)), '1, p == 4);
        wait_out(8);
        @(posedge aclk); #1;
        for (int k = 0; k < 8; k++) begin
            if (k < q_dat.size()) begin
                for (int j = 0; j < 40; j++) exp_d[j*8 +: 8] = 8'(k * 40 + j);
                check($sformatf("t1_dat%0d", k), q_dat[k], exp_d);
                check($sformatf("t1_keep%0d", k), 320'(q_keep[k]), 320'(40'hFF_FFFF_FFFF));
                check($sformatf("t1_last%0d", k), 320'(q_last[k]), 320'(k == 7));
            end
        end
        check("t1_tin", 320'(tin), 320'(40));
        check("t1_tout", 320'(tout), 320'(40));
        check("t1_err", 320'(err), 320'(0));
        check("t1_idle", 320'(m_vld), 320'(0));

        // Single 16-byte packet
        pulse_clear();
        check("t2_clr_tin", 320'(tin), 320'(0));
        check("t2_clr_tout", 320'(tout), 320'(0));
        clr_q();
        pv = pat(8'hA0);
        send(pv, 64'hFFFF, 1'b1);
        wait_out(1);
        @(posedge aclk); #1;
        if (q_dat.size() > 0) begin
            check("t2_keep", 320'(q_keep[0]), 320'(40'h00_0000_FFFF));
            check("t2_last", 320'(q_last[0]), 320'(1));
            check("t2_dat", q_dat[0] & bmask(16), pv[319:0] & bmask(16));
        end
        check("t2_tin", 320'(tin), 320'(2));
        check("t2_tout", 320'(tout), 320'(2));

        // Output backpressure on a full beat
        pulse_clear();
        clr_q();
        m_rdy = 1'b0;
        pv = pat(8'h40);
        send(pv, '1, 1'b0);
        @(negedge aclk);
        snap = m_dat;
        check("t3_vld", 320'(m_vld), 320'(1));
        check("t3_s_rdy", 320'(s_rdy), 320'(0));
        check("t3_dat", m_dat, pv[319:0]);
        check("t3_keep", 320'(m_keep), 320'(40'hFF_FFFF_FFFF));
        check("t3_last", 320'(m_last), 320'(0));
        repeat (9) @(negedge aclk);
        check("t3_hold_dat", m_dat, snap);
        check("t3_hold_vld", 320'(m_vld), 320'(1));
        check("t3_hold_s_rdy", 320'(s_rdy), 320'(0));
        @(posedge aclk); #1 m_rdy = 1'b1;
        @(posedge aclk); #1;
        @(negedge aclk);
        check("t3_resume_s_rdy", 320'(s_rdy), 320'(1));
        check("t3_residual_wait", 320'(m_vld), 320'(0));
        check("t3_one_beat", 320'(q_dat.size()), 320'(1));
        send(pat(8'h80), 64'hFFFF, 1'b1);
        wait_out(2);
        @(posedge aclk); #1;
        if (q_dat.size() > 1) begin
            check("t3_b0_dat", q_dat[0], pv[319:0]);
            check("t3_b0_last", 320'(q_last[0]), 320'(0));
            pv = pat(8'h68);
            check("t3_b1_dat", q_dat[1], pv[319:0]);
            check("t3_b1_keep", 320'(q_keep[1]), 320'(40'hFF_FFFF_FFFF));
            check("t3_b1_last", 320'(q_last[1]), 320'(1));
        end
        check("t3_tin", 320'(tin), 320'(10));
        check("t3_tout", 320'(tout), 320'(10));

        // Non-contiguous keep
        pulse_clear();
        clr_q();
        pv = pat(8'h11);
        send(pv, 64'h0F0F, 1'b1);
        wait_out(1);
        @(posedge aclk); #1;
        check("t4_err", 320'(err), 320'(1));
        if (q_dat.size() > 0) begin
            check("t4_keep", 320'(q_keep[0]), 320'(40'hF));
            check("t4_last", 320'(q_last[0]), 320'(1));
            check("t4_dat", q_dat[0] & bmask(4), pv[319:0] & bmask(4));
        end
        check("t4_tin", 320'(tin), 320'(0));

        // Zero-keep tlast on an empty buffer
        pulse_clear();
        check("t5_err_clr", 320'(err), 320'(0));
        clr_q();
        send('0, 64'h0, 1'b1);
        wait_out(1);
        @(posedge aclk); #1;
        if (q_dat.size() > 0) begin
            check("t5_keep", 320'(q_keep[0]), 320'(0));
            check("t5_last", 320'(q_last[0]), 320'(1));
        end
        check("t5_tin", 320'(tin), 320'(0));
        check("t5_tout", 320'(tout), 320'(0));

        // Reset with 24 bytes buffered mid-packet
        send(pat(8'h30), 64'hFF_FFFF, 1'b0);
        @(negedge aclk);
        check("t6_pre_vld", 320'(m_vld), 320'(0));
        check("t6_pre_tin", 320'(tin), 320'(3));
        #2 aresetn = 1'b0;
        #1;
        check("t6_rst_s_rdy", 320'(s_rdy), 320'(0));
        check("t6_rst_dat", m_dat, 320'(0));
        check("t6_rst_keep", 320'(m_keep), 320'(0));
        check("t6_rst_vld", 320'(m_vld), 320'(0));
        check("t6_rst_tin", 320'(tin), 320'(0));
        @(negedge aclk) aresetn = 1'b1;
        clr_q();
        pv = pat(8'hC0);
        send(pv, 64'hFFFF, 1'b1);
        wait_out(1);
        if (q_dat.size() > 0) begin
            check("t6_keep", 320'(q_keep[0]), 320'(40'h00_0000_FFFF));
            check("t6_dat", q_dat[0] & bmask(16), pv[319:0] & bmask(16));
            check("t6_last", 320'(q_last[0]), 320'(1));
        end

        // stat_clear in the same cycle as an input handshake
        @(posedge aclk); #1;
        s_vld = 1'b1; s_dat = pat(8'h00); s_keep = '1; s_last = 1'b0; stat_clear = 1'b1;
        @(negedge aclk);
        check("t6_clr_hs_rdy", 320'(s_rdy), 320'(1));
        @(posedge aclk); #1;
        s_vld = 1'b0; stat_clear = 1'b0;
        check("t6_clr_wins", 320'(tin), 320'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
